ifetch_axi_master: RTL and testbench

Instruction-fetch read master between the CPU fetch stage and the AXI interconnect. It takes the current program counter and issues a single-beat AXI4 read to instruction memory. It holds the CPU stalled, via `fetch_stall` driving the PC write-enable low, until the instruction word returns, then presents the word to the IF/ID register for one cycle. It is the consumer side of the PC: the PC register produces addresses, and this block turns each one into a bus transaction and an instruction.

---
 rtl/ifetch_axi_master.sv | 141 ++++++++++++++
 tb/tb_ifetch_axi_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_axi_master.sv
// Instruction-fetch AXI4 read master: one single-beat read per PC value, CPU stalled until the word returns.
// Optional macro IFETCH_ERR_EN: adds fetch_err and substitutes a NOP for error responses.
module ifetch_axi_master #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic [31:0]     fetch_addr,
    input  logic            flush,
    output logic            fetch_stall,
    output logic [31:0]     inst,
    output logic            inst_valid,
`ifdef IFETCH_ERR_EN
    output logic            fetch_err,
`endif
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where VALID and READY
    // are both high; ARVALID stays up with a stable ARADDR until ARREADY.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;
`ifdef IFETCH_ERR_EN
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            inst_q  <= '0;
            drop_q  <= 1'b0;
`ifdef IFETCH_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
`ifdef IFETCH_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
`ifdef IFETCH_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    addr_d  = fetch_addr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (flush) drop_d = 1'b1;
                if (ARREADY) state_d = DATA;
            end
            DATA: begin
                if (flush) drop_d = 1'b1;
                if (RVALID && RLAST) begin
                    // A flush arriving with the data still kills that data.
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        inst_d  = RDATA;
`ifdef IFETCH_ERR_EN
                        err_d   = (RRESP != 2'b00);
                        if (RRESP != 2'b00) inst_d = NOP;
`endif
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so the PC is never frozen while the whole system is in reset.
    assign fetch_stall = ~rst & (((state_q == IDLE) & fetch_req) |
                                 (state_q == ADDR) | (state_q == DATA));
    assign inst        = inst_q;
    assign inst_valid  = (state_q == DONE) & ~flush;
`ifdef IFETCH_ERR_EN
    assign fetch_err   = (state_q == DONE) & ~flush & err_q;
`endif

    assign ARID      = MASTER_ID;
    assign ARADDR    = {addr_q[31:2], 2'b00};
    assign ARLEN     = 4'd0;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign ARVALID   = (state_q == ADDR);
    assign RREADY    = (state_q == DATA);
    assign dbg_state = state_q;

    logic unused_inputs;
`ifdef IFETCH_ERR_EN
    assign unused_inputs = ^{RID, addr_q[1:0]};
`else
    assign unused_inputs = ^{RID, RRESP, addr_q[1:0]};
`endif

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Directed bench for ifetch_axi_master: each fetch scenario is turned into a per-cycle
// timeline of expected outputs from its wait/flush parameters, checked every cycle.
module tb_ifetch_axi_master;

    localparam int          ID_W = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            flush;
    logic            fetch_stall;
    logic [31:0]     inst;
    logic            inst_valid;
`ifdef IFETCH_ERR_EN
    logic            fetch_err;
`endif
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;
    logic [1:0]      dbg_state;

    ifetch_axi_master #(.ID_W(ID_W), .MASTER_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
        .fetch_stall(fetch_stall), .inst(inst), .inst_valid(inst_valid),
`ifdef IFETCH_ERR_EN
        .fetch_err(fetch_err),
`endif
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected timeline of the current scenario, indexed by cycle from the request.
    logic        exp_stall[64];
    logic        exp_arvalid[64];
    logic        exp_rready[64];
    logic        exp_ivalid[64];
    logic        exp_err[64];
    logic [31:0] exp_araddr[64];
    logic [31:0] exp_inst[64];
    bit          run = 1'b0;
    int          cyc = 0;
    logic [31:0] model_inst = '0;
    logic [31:0] last_araddr = '0;

    always @(negedge clk) begin
        if (run) begin
            check($sformatf("fetch_stall c%0d", cyc), {31'b0, fetch_stall}, {31'b0, exp_stall[cyc]});
            check($sformatf("ARVALID c%0d", cyc), {31'b0, ARVALID}, {31'b0, exp_arvalid[cyc]});
            check($sformatf("RREADY c%0d", cyc), {31'b0, RREADY}, {31'b0, exp_rready[cyc]});
            check($sformatf("inst_valid c%0d", cyc), {31'b0, inst_valid}, {31'b0, exp_ivalid[cyc]});
            check($sformatf("inst c%0d", cyc), inst, exp_inst[cyc]);
`ifdef IFETCH_ERR_EN
            check($sformatf("fetch_err c%0d", cyc), {31'b0, fetch_err}, {31'b0, exp_err[cyc]});
`endif
            if (exp_arvalid[cyc]) begin
                last_araddr = ARADDR;
                check($sformatf("ARADDR c%0d", cyc), ARADDR, exp_araddr[cyc]);
                check("ARID", {28'b0, ARID}, 32'd0);
                check("ARLEN", {28'b0, ARLEN}, 32'd0);
                check("ARSIZE", {29'b0, ARSIZE}, 32'd2);
                check("ARBURST", {30'b0, ARBURST}, 32'd1);
            end
        end
    end

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        fetch_addr = $urandom;
        flush      = 1'b0;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        RDATA      = $urandom;
        RRESP      = 2'b00;
        RID        = 4'($urandom);
    endtask

    // a: cycles without ARREADY, r: cycles in DATA without RVALID, f: flush cycle (-1 none).
    task automatic run_fetch(input logic [31:0] addr, input int a, input int r, input int f,
                             input logic [31:0] rdata, input logic [1:0] rresp);
        int          d;
        int          n;
        bit          drop;
        bit          rv;
        logic [31:0] new_inst;
        d        = 2 + a + r;
        n        = d + 3;
        drop     = (f >= 1) && (f <= d);
        new_inst = rdata;
`ifdef IFETCH_ERR_EN
        if (rresp != 2'b00) new_inst = NOP;
`endif
        for (int k = 0; k < n; k++) begin
            exp_stall[k]   = (k <= d);
            exp_arvalid[k] = (k >= 1) && (k <= 1 + a);
            exp_araddr[k]  = addr & 32'hFFFF_FFFC;
            exp_rready[k]  = (k >= 2 + a) && (k <= d);
            exp_ivalid[k]  = !drop && (k == d + 1) && (f != d + 1);
            exp_inst[k]    = (k > d && !drop) ? new_inst : model_inst;
            exp_err[k]     = exp_ivalid[k] && (rresp != 2'b00);
        end
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc        = k;
            run        = 1'b1;
            rv         = (k >= 2 + a + r) && (k <= d);
            fetch_req  = (k <= d);
            fetch_addr = (k == 0) ? addr : $urandom;
            flush      = (k == f);
            ARREADY    = (k >= 1 + a);
            RVALID     = rv;
            RLAST      = rv ? 1'b1 : 1'($urandom_range(0, 1));
            RDATA      = rv ? rdata : $urandom;
            RRESP      = rv ? rresp : 2'b00;
            RID        = 4'($urandom);
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        idle_inputs();
        if (!drop) model_inst = new_inst;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        fetch_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset fetch_stall", {31'b0, fetch_stall}, 32'd0);
        check("reset ARVALID", {31'b0, ARVALID}, 32'd0);
        check("reset RREADY", {31'b0, RREADY}, 32'd0);
        check("reset ARADDR", ARADDR, 32'd0);
        check("reset inst", inst, 32'd0);
        check("reset inst_valid", {31'b0, inst_valid}, 32'd0);
        check("reset state", {30'b0, dbg_state}, 32'd0);
        fetch_req = 1'b0;
        rst = 1'b0;

        run_fetch(32'h0000_0104, 0, 0, -1, 32'h0000_0093, 2'b00);
        check("single inst literal", inst, 32'h0000_0093);

        run_fetch(32'h0000_0007, 3, 0, -1, 32'h00A0_0513, 2'b00);
        check("arwait ARADDR literal", last_araddr, 32'h0000_0004);

        run_fetch(32'h0000_0300, 0, 2, 2, 32'hDEAD_BEEF, 2'b00);
        check("flush_data inst kept", inst, 32'h00A0_0513);

        run_fetch(32'h0000_0200, 1, 1, -1, 32'h0011_2233, 2'b00);
        check("after_flush inst literal", inst, 32'h0011_2233);

        run_fetch(32'h0000_0210, 2, 0, 2, 32'h5555_AAAA, 2'b00);   // flush in ADDR
        run_fetch(32'h0000_0220, 0, 1, 4, 32'h0000_0513, 2'b00);   // flush in DONE
        check("flush_done inst updated", inst, 32'h0000_0513);
        run_fetch(32'h0000_0230, 0, 0, 0, 32'h0040_0093, 2'b00);   // flush in IDLE

        run_fetch(32'h0000_0400, 0, 1, -1, 32'h1234_5678, 2'b10);
`ifdef IFETCH_ERR_EN
        check("err inst literal", inst, NOP);
`else
        check("err ignored inst literal", inst, 32'h1234_5678);
`endif

        // Reset in the middle of DATA, then a stray R beat.
        @(posedge clk);
        #1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0500;
        ARREADY    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset state DATA", {30'b0, dbg_state}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("midreset ARVALID", {31'b0, ARVALID}, 32'd0);
        check("midreset RREADY", {31'b0, RREADY}, 32'd0);
        check("midreset inst", inst, 32'd0);
        check("midreset state", {30'b0, dbg_state}, 32'd0);
        check("midreset fetch_stall", {31'b0, fetch_stall}, 32'd0);
        fetch_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_inst = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            RVALID = 1'b1;
            RLAST  = 1'b1;
            RDATA  = $urandom;
            @(negedge clk);
            check($sformatf("late RREADY %0d", k), {31'b0, RREADY}, 32'd0);
            check($sformatf("late inst_valid %0d", k), {31'b0, inst_valid}, 32'd0);
            check($sformatf("late inst %0d", k), inst, model_inst);
            check($sformatf("late state %0d", k), {30'b0, dbg_state}, 32'd0);
        end
        idle_inputs();

        run_fetch(32'h0000_0600, 0, 0, -1, 32'h0000_0073, 2'b00);
        check("post-reset inst literal", inst, 32'h0000_0073);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
